// File: rtl/reg_array_arbiter_if.sv
// Request/response channel between one requester and the register-array arbiter.
// The master side issues commands; the slave side accepts them and returns responses.
interface reg_array_arbiter_if #(
  parameter int bits              = 8,
  parameter int array_select_size = 2
);
  logic                         valid;
  logic                         we;
  logic [array_select_size-1:0] addr;
  logic [bits-1:0]              wdata;
  logic                         ready;
  logic                         rsp_valid;
  logic [bits-1:0]              rsp_rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/reg_array_arbiter.sv
// Round-robin arbiter sharing one register array between two requesters.
// Pipeline: accept (comb grant) -> issue (drive array) -> respond (one-cycle pulse).
module reg_array_arbiter #(
  parameter int bits              = 8,
  parameter int array_select_size = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  reg_array_arbiter_if.slave           req0,
  reg_array_arbiter_if.slave           req1,
  output logic                         ra_R_W,
  output logic [array_select_size-1:0] ra_select,
  output logic [bits-1:0]              ra_d,
  input  logic [bits-1:0]              ra_q
);

  // last_grant holds the id of the most recent winner; reset to 1 so req0 wins first.
  logic                         last_grant;
  logic                         grant0;
  logic                         grant1;
  logic                         hs_p0;
  logic                         id_p0;
  logic                         we_p0;
  logic [array_select_size-1:0] addr_p0;
  logic [bits-1:0]              wdata_p0;

  logic                         vld_p1;
  logic                         id_p1;
  logic                         we_p1;
  logic [array_select_size-1:0] addr_p1;
  logic [bits-1:0]              wdata_p1;

  logic                         vld0_p2;
  logic                         vld1_p2;
  logic [bits-1:0]              rdata0_p2;
  logic [bits-1:0]              rdata1_p2;

  // accept stage
  always_comb begin
    grant0   = req0.valid & (~req1.valid | last_grant);
    grant1   = req1.valid & (~req0.valid | ~last_grant);
    hs_p0    = grant0 | grant1;
    id_p0    = grant1;
    we_p0    = grant1 ? req1.we    : req0.we;
    addr_p0  = grant1 ? req1.addr  : req0.addr;
    wdata_p0 = grant1 ? req1.wdata : req0.wdata;
  end

  assign req0.ready = grant0;
  assign req1.ready = grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (hs_p0) begin
      last_grant <= id_p0;
    end
  end

  // issue stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= hs_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (hs_p0) begin
      id_p1    <= id_p0;
      we_p1    <= we_p0;
      addr_p1  <= addr_p0;
      wdata_p1 <= wdata_p0;
    end
  end

  always_comb begin
    ra_R_W    = vld_p1 & we_p1;
    ra_select = vld_p1 ? addr_p1  : '0;
    ra_d      = vld_p1 ? wdata_p1 : '0;
  end

  // response stage; each requester's rdata holds between its own responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld0_p2   <= 1'b0;
      vld1_p2   <= 1'b0;
      rdata0_p2 <= '0;
      rdata1_p2 <= '0;
    end else begin
      vld0_p2 <= vld_p1 & ~id_p1;
      vld1_p2 <= vld_p1 & id_p1;
      if (vld_p1 && !id_p1) begin
        rdata0_p2 <= we_p1 ? '0 : ra_q;
      end
      if (vld_p1 && id_p1) begin
        rdata1_p2 <= we_p1 ? '0 : ra_q;
      end
    end
  end

  assign req0.rsp_valid = vld0_p2;
  assign req0.rsp_rdata = rdata0_p2;
  assign req1.rsp_valid = vld1_p2;
  assign req1.rsp_rdata = rdata1_p2;

endmodule

// File: tb/tb_reg_array_arbiter.sv
// Bench for reg_array_arbiter: behavioural 4x8 array plus a grant-order scoreboard
// predicting array drive, responses and ready for every cycle.
module tb_reg_array_arbiter;
  localparam int BITS  = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int MAXC  = 2048;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  reg_array_arbiter_if #(.bits(BITS), .array_select_size(AW)) req0_if ();
  reg_array_arbiter_if #(.bits(BITS), .array_select_size(AW)) req1_if ();

  logic            ra_R_W;
  logic [AW-1:0]   ra_select;
  logic [BITS-1:0] ra_d;
  logic [BITS-1:0] ra_q;

  reg_array_arbiter #(.bits(BITS), .array_select_size(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0_if),
    .req1      (req1_if),
    .ra_R_W    (ra_R_W),
    .ra_select (ra_select),
    .ra_d      (ra_d),
    .ra_q      (ra_q)
  );

  // the shared register array
  logic [BITS-1:0] arr [DEPTH];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) arr[i] <= '0;
    end else if (ra_R_W) begin
      arr[ra_select] <= ra_d;
    end
  end
  assign ra_q = arr[ra_select];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int prev = 1;
  logic [BITS-1:0] ref_mem [DEPTH];
  logic [BITS-1:0] held [2];
  bit   g_vld   [MAXC];
  int   g_id    [MAXC];
  bit   g_we    [MAXC];
  int   g_addr  [MAXC];
  int   g_wdata [MAXC];
  int   g_rdata [MAXC];
  bit   acc0, acc1;
  logic r0_seen, r1_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s cycle=%0d: observed=%0h expected=%0h", tag, cyc, obs, want);
    end
  endtask

  task automatic check_outputs();
    bit iv;
    bit rv [2];
    iv = (cyc >= 1) && g_vld[cyc-1];
    rv[0] = 1'b0;
    rv[1] = 1'b0;
    if (cyc >= 2 && g_vld[cyc-2]) begin
      rv[g_id[cyc-2]] = 1'b1;
      held[g_id[cyc-2]] = g_rdata[cyc-2][BITS-1:0];
    end
    chk("ra_R_W",     ra_R_W,            32'(iv && g_we[cyc-1]));
    chk("ra_select",  ra_select,         iv ? g_addr[cyc-1]  : 0);
    chk("ra_d",       ra_d,              iv ? g_wdata[cyc-1] : 0);
    chk("rsp0_valid", req0_if.rsp_valid, 32'(rv[0]));
    chk("rsp1_valid", req1_if.rsp_valid, 32'(rv[1]));
    chk("rsp0_rdata", req0_if.rsp_rdata, held[0]);
    chk("rsp1_rdata", req1_if.rsp_rdata, held[1]);
  endtask

  task automatic drive(input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [BITS-1:0] d0,
                       input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [BITS-1:0] d1);
    req0_if.valid = v0; req0_if.we = w0; req0_if.addr = a0; req0_if.wdata = d0;
    req1_if.valid = v1; req1_if.we = w1; req1_if.addr = a1; req1_if.wdata = d1;
  endtask

  // Entered and left just after a rising edge; one call is one clock cycle.
  task automatic run_cycle(input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [BITS-1:0] d0,
                           input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [BITS-1:0] d1);
    bit e0, e1;
    check_outputs();
    drive(v0, w0, a0, d0, v1, w1, a1, d1);
    #1;
    e0 = v0 && (!v1 || prev == 1);
    e1 = v1 && (!v0 || prev == 0);
    r0_seen = req0_if.ready;
    r1_seen = req1_if.ready;
    chk("ready0", r0_seen, 32'(e0));
    chk("ready1", r1_seen, 32'(e1));
    chk("one_ready", 32'(r0_seen & r1_seen), 0);
    acc0 = e0;
    acc1 = e1;
    g_vld[cyc] = e0 || e1;
    if (e0 || e1) begin
      g_id[cyc]    = e1 ? 1 : 0;
      g_we[cyc]    = e1 ? w1 : w0;
      g_addr[cyc]  = e1 ? a1 : a0;
      g_wdata[cyc] = e1 ? d1 : d0;
      g_rdata[cyc] = g_we[cyc] ? 0 : ref_mem[g_addr[cyc]];
      if (g_we[cyc]) ref_mem[g_addr[cyc]] = g_wdata[cyc][BITS-1:0];
      prev = g_id[cyc];
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asserts rst_n mid-cycle, optionally holds it over extra edges, releases before the next edge.
  task automatic do_reset(input bit precheck, input logic v0, input logic v1, input int hold);
    if (precheck) check_outputs();
    drive(v0, 0, 0, 0, v1, 0, 0, 0);
    rst_n = 1'b0;
    prev = 1;
    held[0] = '0;
    held[1] = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    g_vld[cyc] = 0;
    if (cyc >= 1) g_vld[cyc-1] = 0;
    if (cyc >= 2) g_vld[cyc-2] = 0;
    #1;
    check_outputs();
    chk("rst_ready0", req0_if.ready, 32'(v0));
    chk("rst_ready1", req1_if.ready, 32'(v1 && !v0));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      g_vld[cyc] = 0;
      check_outputs();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    g_vld[cyc] = 0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [BITS-1:0] k;
    logic pv0, pw0, pv1, pw1;
    logic [AW-1:0] pa0, pa1;
    logic [BITS-1:0] pd0, pd1;
    bit pend0, pend1;

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // reset with both requesters asserting valid, then first contention goes to req0
    do_reset(0, 1, 1, 2);
    run_cycle(1, 0, 0, 0, 1, 0, 1, 0);
    chk("t1_first_ready0", r0_seen, 1);
    chk("t1_first_ready1", r1_seen, 0);
    run_cycle(0, 0, 0, 0, 1, 0, 1, 0);
    idle(3);

    // write then read the same register from req0
    run_cycle(1, 1, 2, 8'hA5, 0, 0, 0, 0);
    chk("t2_ra_R_W", ra_R_W, 1);
    chk("t2_ra_select", ra_select, 2);
    chk("t2_ra_d", ra_d, 8'hA5);
    run_cycle(1, 0, 2, 0, 0, 0, 0, 0);
    chk("t2_wr_ack_valid", req0_if.rsp_valid, 1);
    chk("t2_wr_ack_rdata", req0_if.rsp_rdata, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_rd_valid", req0_if.rsp_valid, 1);
    chk("t2_rd_rdata", req0_if.rsp_rdata, 8'hA5);
    idle(2);

    // sustained contention alternates grants
    k = 8'd1;
    for (int i = 0; i < 6; i++) begin
      run_cycle(1, 1, 0, k, 1, 0, 0, 0);
      chk("t3_ready0_alt", r0_seen, 32'(i % 2));
      if (acc0) k++;
    end
    idle(3);

    // back-to-back write/read on req1
    run_cycle(0, 0, 0, 0, 1, 1, 3, 8'h3C);
    run_cycle(0, 0, 0, 0, 1, 0, 3, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_raw_valid", req1_if.rsp_valid, 1);
    chk("t4_raw_rdata", req1_if.rsp_rdata, 8'h3C);
    idle(2);

    // reset pulse while a read is in the issue stage
    run_cycle(1, 0, 1, 0, 0, 0, 0, 0);
    do_reset(1, 0, 0, 0);
    chk("t5_no_rsp0", req0_if.rsp_valid, 0);
    chk("t5_ra_R_W", ra_R_W, 0);
    idle(2);

    // randomized traffic; a requester holds its command until accepted
    pend0 = 0; pend1 = 0;
    pv0 = 0; pw0 = 0; pa0 = 0; pd0 = 0;
    pv1 = 0; pw1 = 0; pa1 = 0; pd1 = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        do_reset(1, 0, 0, 1);
        pend0 = 0;
        pend1 = 0;
      end
      if (!pend0) begin
        pv0 = ($urandom_range(0, 99) < 65);
        pw0 = $urandom_range(0, 1);
        pa0 = AW'($urandom_range(0, DEPTH-1));
        pd0 = BITS'($urandom);
      end
      if (!pend1) begin
        pv1 = ($urandom_range(0, 99) < 65);
        pw1 = $urandom_range(0, 1);
        pa1 = AW'($urandom_range(0, DEPTH-1));
        pd1 = BITS'($urandom);
      end
      run_cycle(pv0, pw0, pa0, pd0, pv1, pw1, pa1, pd1);
      pend0 = pv0 && !acc0;
      pend1 = pv1 && !acc1;
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
